hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Drives the write-enable and flush of the
//  IF/ID pipeline register, the PC write-enable and ID/EX bubble insertion. Handles load-use

---
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The controller side uses the slave modport; the datapath side uses master.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  idex_memread;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic [REG_ADDR_W-1:0] ifid_rs;
  logic [REG_ADDR_W-1:0] ifid_rt;
  logic                  ifid_uses_rt;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  pipe_freeze;
  logic [CNT_W-1:0]      stall_cnt;
  logic [1:0]            state;

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, stall_cnt, state
  );

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, stall_cnt, state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait
// freezes for the 5-stage core, plus a saturating count of cycles the PC was held.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [2:0]       LU_LOAD = 3'(LU_CYCLES - 1);
  localparam logic [2:0]       FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stallCnt;

  state_t     w_nextState;
  logic [2:0] w_nextCnt;
  logic       w_luHaz;
  logic       w_pcWrite;
  logic       w_ifidWrite;
  logic       w_ifidFlush;
  logic       w_idexBubble;
  logic       w_pipeFreeze;

  assign w_luHaz = bus.idex_memread && (bus.idex_rt != '0) &&
                   ((bus.idex_rt == bus.ifid_rs) ||
                    (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  // MEM_WAIT shares the RUN decision once memory is ready, giving a zero-cycle exit.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_pcWrite    = 1'b1;
    w_ifidWrite  = 1'b1;
    w_ifidFlush  = 1'b0;
    w_idexBubble = 1'b0;
    w_pipeFreeze = 1'b0;
    if (rst) begin
      w_pcWrite    = 1'b0;
      w_ifidWrite  = 1'b0;
      w_ifidFlush  = 1'b1;
      w_idexBubble = 1'b1;
    end else if (bus.mem_busy) begin
      w_pcWrite    = 1'b0;
      w_ifidWrite  = 1'b0;
      w_pipeFreeze = 1'b1;
      if (r_state == RUN) w_nextState = MEM_WAIT;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          w_nextState = RUN;
          if (bus.branch_taken) begin
            w_ifidFlush  = 1'b1;
            w_idexBubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_nextState = FLUSH;
              w_nextCnt   = FL_LOAD;
            end
          end else if (w_luHaz) begin
            w_pcWrite    = 1'b0;
            w_ifidWrite  = 1'b0;
            w_idexBubble = 1'b1;
            if (LU_CYCLES > 1) begin
              w_nextState = LU_STALL;
              w_nextCnt   = LU_LOAD;
            end
          end
        end
        LU_STALL: begin
          w_pcWrite    = 1'b0;
          w_ifidWrite  = 1'b0;
          w_idexBubble = 1'b1;
          w_nextCnt    = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_nextState = RUN;
        end
        FLUSH: begin
          w_ifidFlush  = 1'b1;
          w_idexBubble = 1'b1;
          w_nextCnt    = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_nextState = RUN;
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_cnt      <= 3'd0;
      r_stallCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (!w_pcWrite && (r_stallCnt != CNT_MAX)) r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign bus.pc_write    = w_pcWrite;
  assign bus.ifid_write  = w_ifidWrite;
  assign bus.ifid_flush  = w_ifidFlush;
  assign bus.idex_bubble = w_idexBubble;
  assign bus.pipe_freeze = w_pipeFreeze;
  assign bus.stall_cnt   = r_stallCnt;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two parameterisations driven by the same stimulus and
// compared every cycle against a counting model of stall/flush work still owed.
module tb_hazard_stall_ctrl;

  localparam int LUA = 1, FLA = 1, CWA = 16;
  localparam int LUB = 3, FLB = 2, CWB = 4;

  typedef struct {
    int     luLeft;
    int     flLeft;
    bit     memWait;
    longint stallCnt;
    bit     valid;
  } mdl_t;

  typedef struct {
    bit pc;
    bit ifw;
    bit fl;
    bit bub;
    bit frz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread = 1'b0;
  logic [4:0] idexRt = '0;
  logic [4:0] ifidRs = '0;
  logic [4:0] ifidRt = '0;
  logic       usesRt = 1'b0;
  logic       branch = 1'b0;
  logic       busy = 1'b0;

  int checkCount = 0;
  int failCount  = 0;
  mdl_t mA = '{0, 0, 1'b0, 0, 1'b0};
  mdl_t mB = '{0, 0, 1'b0, 0, 1'b0};

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CWA)) ifA ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CWB)) ifB ();

  assign ifA.idex_memread = memread;
  assign ifA.idex_rt      = idexRt;
  assign ifA.ifid_rs      = ifidRs;
  assign ifA.ifid_rt      = ifidRt;
  assign ifA.ifid_uses_rt = usesRt;
  assign ifA.branch_taken = branch;
  assign ifA.mem_busy     = busy;
  assign ifB.idex_memread = memread;
  assign ifB.idex_rt      = idexRt;
  assign ifB.ifid_rs      = ifidRs;
  assign ifB.ifid_rt      = ifidRt;
  assign ifB.ifid_uses_rt = usesRt;
  assign ifB.branch_taken = branch;
  assign ifB.mem_busy     = busy;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_CYCLES(LUA), .FLUSH_CYCLES(FLA), .CNT_W(CWA)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_CYCLES(LUB), .FLUSH_CYCLES(FLB), .CNT_W(CWB)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave));

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic bit loadUse();
    return memread && (idexRt != 0) && ((idexRt == ifidRs) || (usesRt && (idexRt == ifidRt)));
  endfunction

  // Outputs follow from how much stall or flush work is still owed, not from an encoding.
  function automatic exp_t predict(mdl_t m, bit haz);
    exp_t e;
    if (rst)              e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    else if (busy)        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    else if (m.luLeft > 0) e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    else if (m.flLeft > 0) e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    else if (branch)      e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    else if (haz)         e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    else                  e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    return e;
  endfunction

  function automatic int expState(mdl_t m);
    if (m.memWait) return 2;
    if (m.luLeft > 0) return 1;
    if (m.flLeft > 0) return 3;
    return 0;
  endfunction

  function automatic mdl_t advance(mdl_t m, exp_t e, bit haz, int luCyc, int flCyc, longint cntMax);
    mdl_t n = m;
    if (rst) return '{0, 0, 1'b0, 0, 1'b1};
    if (busy) begin
      if (m.luLeft == 0 && m.flLeft == 0) n.memWait = 1'b1;
    end else begin
      n.memWait = 1'b0;
      if (m.luLeft > 0)      n.luLeft--;
      else if (m.flLeft > 0) n.flLeft--;
      else if (branch)       n.flLeft = flCyc - 1;
      else if (haz)          n.luLeft = luCyc - 1;
    end
    if (!e.pc && n.stallCnt < cntMax) n.stallCnt++;
    return n;
  endfunction

  task automatic compareInst(input string tag, input exp_t e, input mdl_t m,
                             input logic pc, input logic ifw, input logic fl, input logic bub,
                             input logic frz, input logic [1:0] st, input logic [63:0] sc);
    checkOutput({tag, ".pc_write"}, 64'(pc), 64'(e.pc));
    checkOutput({tag, ".ifid_write"}, 64'(ifw), 64'(e.ifw));
    checkOutput({tag, ".ifid_flush"}, 64'(fl), 64'(e.fl));
    checkOutput({tag, ".idex_bubble"}, 64'(bub), 64'(e.bub));
    checkOutput({tag, ".pipe_freeze"}, 64'(frz), 64'(e.frz));
    if (m.valid) begin
      checkOutput({tag, ".state"}, 64'(st), 64'(expState(m)));
      checkOutput({tag, ".stall_cnt"}, sc, 64'(m.stallCnt));
    end
  endtask

  always @(negedge clk) begin
    exp_t eA, eB;
    bit haz;
    haz = loadUse();
    eA = predict(mA, haz);
    eB = predict(mB, haz);
    compareInst("A", eA, mA, ifA.pc_write, ifA.ifid_write, ifA.ifid_flush, ifA.idex_bubble,
                ifA.pipe_freeze, ifA.state, 64'(ifA.stall_cnt));
    compareInst("B", eB, mB, ifB.pc_write, ifB.ifid_write, ifB.ifid_flush, ifB.idex_bubble,
                ifB.pipe_freeze, ifB.state, 64'(ifB.stall_cnt));
    mA = advance(mA, eA, haz, LUA, FLA, (64'd1 << CWA) - 1);
    mB = advance(mB, eB, haz, LUB, FLB, (64'd1 << CWB) - 1);
  end

  task automatic applyStimulus(input bit r, input bit mr, input int rt, input int rs,
                               input int rtIf, input bit ur, input bit br, input bit mb);
    @(posedge clk);
    #1;
    rst     = r;
    memread = mr;
    idexRt  = 5'(rt);
    ifidRs  = 5'(rs);
    ifidRt  = 5'(rtIf);
    usesRt  = ur;
    branch  = br;
    busy    = mb;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("reset.ifid_flush", 64'(ifA.ifid_flush), 64'd1);
    checkOutput("reset.pc_write", 64'(ifA.pc_write), 64'd0);
    checkOutput("reset.state", 64'(ifA.state), 64'd0);
    checkOutput("reset.stall_cnt", 64'(ifA.stall_cnt), 64'd0);

    idle();
    checkOutput("run.pc_write", 64'(ifA.pc_write), 64'd1);

    applyStimulus(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu.A.pc_write", 64'(ifA.pc_write), 64'd0);
    checkOutput("lu.A.idex_bubble", 64'(ifA.idex_bubble), 64'd1);
    checkOutput("lu.B.state0", 64'(ifB.state), 64'd0);
    idle();
    checkOutput("lu.A.stall_cnt", 64'(ifA.stall_cnt), 64'd1);
    checkOutput("lu.A.resume", 64'(ifA.pc_write), 64'd1);
    checkOutput("lu.B.state1a", 64'(ifB.state), 64'd1);
    checkOutput("lu.B.pc_write", 64'(ifB.pc_write), 64'd0);
    idle();
    checkOutput("lu.B.state1b", 64'(ifB.state), 64'd1);
    idle();
    checkOutput("lu.B.state_back", 64'(ifB.state), 64'd0);
    checkOutput("lu.B.stall_cnt", 64'(ifB.stall_cnt), 64'd3);

    applyStimulus(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu.rt0.pc_write", 64'(ifA.pc_write), 64'd1);

    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("br.B.ifid_flush", 64'(ifB.ifid_flush), 64'd1);
    checkOutput("br.B.pc_write", 64'(ifB.pc_write), 64'd1);
    idle();
    checkOutput("br.B.flush2", 64'(ifB.ifid_flush), 64'd1);
    checkOutput("br.B.state3", 64'(ifB.state), 64'd3);
    checkOutput("br.A.flush_done", 64'(ifA.ifid_flush), 64'd0);
    idle();
    checkOutput("br.B.flush_done", 64'(ifB.ifid_flush), 64'd0);

    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      checkOutput("mw.B.pipe_freeze", 64'(ifB.pipe_freeze), 64'd1);
      checkOutput("mw.B.state_hold", 64'(ifB.state), 64'd3);
    end
    idle();
    checkOutput("mw.B.last_flush", 64'(ifB.ifid_flush), 64'd1);
    checkOutput("mw.B.stall_cnt", 64'(ifB.stall_cnt), 64'd7);
    checkOutput("mw.A.stall_cnt", 64'(ifA.stall_cnt), 64'd5);
    idle();
    checkOutput("mw.B.state_run", 64'(ifB.state), 64'd0);

    applyStimulus(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("prio.A.pipe_freeze", 64'(ifA.pipe_freeze), 64'd1);
    checkOutput("prio.B.pc_write", 64'(ifB.pc_write), 64'd0);
    checkOutput("prio.B.ifid_flush", 64'(ifB.ifid_flush), 64'd0);
    idle();
    checkOutput("prio.A.state_memwait", 64'(ifA.state), 64'd2);
    checkOutput("prio.A.zero_cycle_exit", 64'(ifA.pc_write), 64'd1);

    applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    checkOutput("sat.B.stall_cnt", 64'(ifB.stall_cnt), 64'd15);
    checkOutput("sat.A.stall_cnt", 64'(ifA.stall_cnt), 64'd20);

    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
